// File: rtl/public_axi_write_ctrl_ysyx_23060136_pkg.sv
// Shared definitions for the AXI write controller: write FSM states,
// AXI response/burst encodings and size helpers used by the alignment
// logic.
package DEFINES_ysyx_23060136;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } wstate_t;

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] INCR = 2'b01;

    // Byte-lane mask for an access of 2^size bytes starting at lane 0.
    function automatic logic [7:0] size_to_mask(input logic [2:0] size);
        case (size)
            3'd0:    size_to_mask = 8'h01;
            3'd1:    size_to_mask = 8'h03;
            3'd2:    size_to_mask = 8'h0F;
            3'd3:    size_to_mask = 8'hFF;
            default: size_to_mask = 8'h00;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_to_align(input logic [2:0] size);
        case (size)
            3'd0:    size_to_align = 3'b000;
            3'd1:    size_to_align = 3'b001;
            3'd2:    size_to_align = 3'b011;
            3'd3:    size_to_align = 3'b111;
            default: size_to_align = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/public_axi_write_ctrl_ysyx_23060136_align.sv
// Store alignment: places LSB-justified store data onto its byte lanes of
// the 64-bit bus, builds the matching strobe and flags stores that are
// misaligned or use an illegal size.
// Ports:
//   off      in   byte offset within the bus word (address bits [2:0])
//   size     in   log2 of access bytes
//   data_in  in   LSB-justified store data
//   data_out out  data shifted to its byte lanes
//   strb     out  write strobe
//   bad      out  illegal size or misaligned address
import DEFINES_ysyx_23060136::*;

module write_align_ysyx_23060136 #(
    parameter int DATA_W = 64
) (
    input  logic [2:0]          off,
    input  logic [2:0]          size,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    output logic [DATA_W/8-1:0] strb,
    output logic                bad
);

    localparam int STRB_W = DATA_W / 8;

    logic [STRB_W-1:0] mask;

    assign mask     = STRB_W'(size_to_mask(size));
    assign data_out = data_in << {off, 3'b000};
    assign strb     = mask << off;
    assign bad      = (size > 3'd3) || ((off & size_to_align(size)) != 3'b000);

endmodule

// File: rtl/public_axi_write_ctrl_ysyx_23060136.sv
// AXI4 write-channel sequencer for MEM-stage stores. Accepts one store at a
// time, issues single-beat AW and W transfers, waits for B and reports
// completion plus a sticky error flag back to MEM. Misaligned or
// illegal-size stores complete with an error and never reach the bus.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   MEM_w*              store request (addr/data/size, valid/ready)
//   MEM_wdone_*         completion handshake back to MEM
//   WRITE_error         error status of the current store
//   WRITE_busy          high whenever a store is in progress
//   io_master_aw/w/b*   AXI4 master write channels
import DEFINES_ysyx_23060136::*;

module public_axi_write_ctrl_ysyx_23060136 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int AXI_ID = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   MEM_waddr,
    input  logic [DATA_W-1:0]   MEM_wdata,
    input  logic [2:0]          MEM_wsize,
    input  logic                MEM_wreq_valid,
    output logic                MEM_wreq_ready,
    output logic                MEM_wdone_valid,
    input  logic                MEM_wdone_ready,
    output logic                WRITE_error,
    output logic                WRITE_busy,
    input  logic                io_master_awready,
    output logic                io_master_awvalid,
    output logic [ADDR_W-1:0]   io_master_awaddr,
    output logic [ID_W-1:0]     io_master_awid,
    output logic [7:0]          io_master_awlen,
    output logic [2:0]          io_master_awsize,
    output logic [1:0]          io_master_awburst,
    input  logic                io_master_wready,
    output logic                io_master_wvalid,
    output logic [DATA_W-1:0]   io_master_wdata,
    output logic [DATA_W/8-1:0] io_master_wstrb,
    output logic                io_master_wlast,
    output logic                io_master_bready,
    input  logic                io_master_bvalid,
    input  logic [1:0]          io_master_bresp,
    input  logic [ID_W-1:0]     io_master_bid
);

    localparam logic [ID_W-1:0] ID = ID_W'(AXI_ID);

    wstate_t                state, state_next;
    logic                   aw_done, aw_done_next;
    logic                   w_done, w_done_next;
    logic                   err_next;
    logic                   accept;
    logic                   aw_ok, w_ok;
    // Keeps wreq_ready low while reset is held and for the first cycle after.
    logic                   run;
    logic [DATA_W-1:0]      al_data;
    logic [DATA_W/8-1:0]    al_strb;
    logic                   al_bad;

    write_align_ysyx_23060136 #(.DATA_W(DATA_W)) u_align (
        .off      (MEM_waddr[2:0]),
        .size     (MEM_wsize),
        .data_in  (MEM_wdata),
        .data_out (al_data),
        .strb     (al_strb),
        .bad      (al_bad)
    );

    assign MEM_wreq_ready    = run && (state == IDLE);
    assign MEM_wdone_valid   = (state == DONE);
    assign WRITE_busy        = (state != IDLE);
    assign io_master_awvalid = (state == SEND) && !aw_done;
    assign io_master_wvalid  = (state == SEND) && !w_done;
    assign io_master_wlast   = io_master_wvalid;
    assign io_master_bready  = (state == RESP);
    assign io_master_awid    = ID;
    assign io_master_awlen   = 8'd0;
    assign io_master_awburst = INCR;

    assign accept = MEM_wreq_valid && MEM_wreq_ready;
    // A channel counts as finished if it completed earlier or handshakes now.
    assign aw_ok  = aw_done || io_master_awready;
    assign w_ok   = w_done  || io_master_wready;

    always_comb begin
        state_next   = state;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        err_next     = WRITE_error;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = al_bad ? DONE : SEND;
                    err_next   = al_bad;
                end
            end
            SEND: begin
                if (aw_ok && w_ok) begin
                    state_next   = RESP;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end else begin
                    aw_done_next = aw_ok;
                    w_done_next  = w_ok;
                end
            end
            RESP: begin
                if (io_master_bvalid) begin
                    state_next = DONE;
                    err_next   = (io_master_bresp != OKAY) || (io_master_bid != ID);
                end
            end
            DONE: begin
                if (MEM_wdone_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            WRITE_error <= 1'b0;
            run         <= 1'b0;
        end else begin
            state       <= state_next;
            aw_done     <= aw_done_next;
            w_done      <= w_done_next;
            WRITE_error <= err_next;
            run         <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_master_awaddr <= '0;
            io_master_awsize <= '0;
            io_master_wdata  <= '0;
            io_master_wstrb  <= '0;
        end else if (accept) begin
            io_master_awaddr <= MEM_waddr;
            io_master_awsize <= MEM_wsize;
            io_master_wdata  <= al_data;
            io_master_wstrb  <= al_strb;
        end
    end

endmodule

// File: tb/tb_public_axi_write_ctrl_ysyx_23060136.sv
module tb_public_axi_write_ctrl_ysyx_23060136;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] MEM_waddr = '0;
    logic [63:0] MEM_wdata = '0;
    logic [2:0]  MEM_wsize = '0;
    logic        MEM_wreq_valid = 1'b0;
    logic        MEM_wreq_ready;
    logic        MEM_wdone_valid;
    logic        MEM_wdone_ready = 1'b0;
    logic        WRITE_error;
    logic        WRITE_busy;
    logic        awready = 1'b0;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready = 1'b0;
    logic        wvalid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bready;
    logic        bvalid = 1'b0;
    logic [1:0]  bresp = '0;
    logic [3:0]  bid = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    public_axi_write_ctrl_ysyx_23060136 dut (
        .clk               (clk),
        .rst               (rst),
        .MEM_waddr         (MEM_waddr),
        .MEM_wdata         (MEM_wdata),
        .MEM_wsize         (MEM_wsize),
        .MEM_wreq_valid    (MEM_wreq_valid),
        .MEM_wreq_ready    (MEM_wreq_ready),
        .MEM_wdone_valid   (MEM_wdone_valid),
        .MEM_wdone_ready   (MEM_wdone_ready),
        .WRITE_error       (WRITE_error),
        .WRITE_busy        (WRITE_busy),
        .io_master_awready (awready),
        .io_master_awvalid (awvalid),
        .io_master_awaddr  (awaddr),
        .io_master_awid    (awid),
        .io_master_awlen   (awlen),
        .io_master_awsize  (awsize),
        .io_master_awburst (awburst),
        .io_master_wready  (wready),
        .io_master_wvalid  (wvalid),
        .io_master_wdata   (wdata),
        .io_master_wstrb   (wstrb),
        .io_master_wlast   (wlast),
        .io_master_bready  (bready),
        .io_master_bvalid  (bvalid),
        .io_master_bresp   (bresp),
        .io_master_bid     (bid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge after the accept edge.
    task automatic start(input logic [31:0] a, input logic [63:0] d, input logic [2:0] s);
        check("wreq_ready_idle", 64'(MEM_wreq_ready), 64'd1);
        MEM_waddr      = a;
        MEM_wdata      = d;
        MEM_wsize      = s;
        MEM_wreq_valid = 1'b1;
        @(negedge clk);
        MEM_wreq_valid = 1'b0;
    endtask

    // Called at a negedge in RESP; returns at the negedge in DONE.
    task automatic b_resp(input logic [1:0] r, input logic [3:0] id);
        check("bready_resp", 64'(bready), 64'd1);
        bvalid = 1'b1;
        bresp  = r;
        bid    = id;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = '0;
        bid    = '0;
        check("bready_after_b", 64'(bready), 64'd0);
    endtask

    task automatic consume();
        check("wdone_valid_pre", 64'(MEM_wdone_valid), 64'd1);
        MEM_wdone_ready = 1'b1;
        @(negedge clk);
        MEM_wdone_ready = 1'b0;
        check("wdone_valid_post", 64'(MEM_wdone_valid), 64'd0);
        check("busy_post", 64'(WRITE_busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_state_busy", 64'(WRITE_busy), 64'd0);
        check("rst_wreq_ready", 64'(MEM_wreq_ready), 64'd0);
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_bready", 64'(bready), 64'd0);
        check("rst_wdone", 64'(MEM_wdone_valid), 64'd0);
        check("rst_error", 64'(WRITE_error), 64'd0);
        check("rst_awaddr", 64'(awaddr), 64'd0);
        check("rst_wdata", wdata, 64'd0);
        check("rst_wstrb", 64'(wstrb), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: sw at offset 4, all channels ready immediately
        awready = 1'b1;
        wready  = 1'b1;
        start(32'h8000_0004, 64'h1234_5678, 3'd2);
        check("t1_awvalid", 64'(awvalid), 64'd1);
        check("t1_wvalid", 64'(wvalid), 64'd1);
        check("t1_wlast", 64'(wlast), 64'd1);
        check("t1_awaddr", 64'(awaddr), 64'h8000_0004);
        check("t1_awsize", 64'(awsize), 64'd2);
        check("t1_awlen", 64'(awlen), 64'd0);
        check("t1_awburst", 64'(awburst), 64'd1);
        check("t1_awid", 64'(awid), 64'd0);
        check("t1_wdata", wdata, 64'h1234_5678_0000_0000);
        check("t1_wstrb", 64'(wstrb), 64'hF0);
        check("t1_busy", 64'(WRITE_busy), 64'd1);
        check("t1_wreq_ready", 64'(MEM_wreq_ready), 64'd0);
        check("t1_wdone_c1", 64'(MEM_wdone_valid), 64'd0);
        @(negedge clk);
        check("t1_awvalid_resp", 64'(awvalid), 64'd0);
        check("t1_wvalid_resp", 64'(wvalid), 64'd0);
        check("t1_wdone_c2", 64'(MEM_wdone_valid), 64'd0);
        b_resp(2'b00, 4'h0);
        check("t1_wdone_c3", 64'(MEM_wdone_valid), 64'd1);
        check("t1_error", 64'(WRITE_error), 64'd0);
        consume();

        // 2: sb at offset 3, W accepted first, AW accepted later
        awready = 1'b0;
        wready  = 1'b1;
        start(32'h8000_0003, 64'hAB, 3'd0);
        check("t2_awvalid", 64'(awvalid), 64'd1);
        check("t2_wvalid", 64'(wvalid), 64'd1);
        check("t2_wstrb", 64'(wstrb), 64'h08);
        check("t2_wdata", wdata, 64'h0000_0000_AB00_0000);
        check("t2_awaddr", 64'(awaddr), 64'h8000_0003);
        check("t2_awsize", 64'(awsize), 64'd0);
        @(negedge clk);
        wready = 1'b0;
        check("t2_wvalid_drop", 64'(wvalid), 64'd0);
        check("t2_awvalid_hold", 64'(awvalid), 64'd1);
        check("t2_no_resp", 64'(bready), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("t2_awvalid_wait", 64'(awvalid), 64'd1);
            check("t2_wvalid_wait", 64'(wvalid), 64'd0);
            check("t2_no_resp_wait", 64'(bready), 64'd0);
        end
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        check("t2_awvalid_done", 64'(awvalid), 64'd0);
        b_resp(2'b00, 4'h0);
        check("t2_error", 64'(WRITE_error), 64'd0);
        consume();

        // 3: misaligned sh, no bus traffic
        start(32'h8000_0001, 64'hBEEF, 3'd1);
        check("t3_wdone", 64'(MEM_wdone_valid), 64'd1);
        check("t3_error", 64'(WRITE_error), 64'd1);
        check("t3_awvalid", 64'(awvalid), 64'd0);
        check("t3_wvalid", 64'(wvalid), 64'd0);
        check("t3_busy", 64'(WRITE_busy), 64'd1);
        consume();
        check("t3_error_sticky", 64'(WRITE_error), 64'd1);

        // 4a: sd with SLVERR response
        awready = 1'b1;
        wready  = 1'b1;
        start(32'h8000_0008, 64'h1122_3344_5566_7788, 3'd3);
        check("t4a_error_cleared", 64'(WRITE_error), 64'd0);
        check("t4a_wstrb", 64'(wstrb), 64'hFF);
        check("t4a_wdata", wdata, 64'h1122_3344_5566_7788);
        @(negedge clk);
        b_resp(2'b10, 4'h0);
        check("t4a_error", 64'(WRITE_error), 64'd1);
        consume();

        // 4b: sh with wrong bid
        start(32'h8000_0010, 64'hCAFE, 3'd1);
        check("t4b_error_cleared", 64'(WRITE_error), 64'd0);
        check("t4b_wstrb", 64'(wstrb), 64'h03);
        check("t4b_wdata", wdata, 64'h0000_0000_0000_CAFE);
        @(negedge clk);
        b_resp(2'b00, 4'h3);
        check("t4b_error", 64'(WRITE_error), 64'd1);
        consume();

        // 5: good sh at offset 6, completion held off for 5 cycles
        start(32'h8000_0006, 64'h5A5A, 3'd1);
        check("t5_error_cleared", 64'(WRITE_error), 64'd0);
        check("t5_wstrb", 64'(wstrb), 64'hC0);
        check("t5_wdata", wdata, 64'h5A5A_0000_0000_0000);
        @(negedge clk);
        b_resp(2'b00, 4'h0);
        check("t5_error", 64'(WRITE_error), 64'd0);
        MEM_waddr      = 32'h8000_0040;
        MEM_wsize      = 3'd2;
        MEM_wreq_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t5_wdone_hold", 64'(MEM_wdone_valid), 64'd1);
            check("t5_wreq_ready", 64'(MEM_wreq_ready), 64'd0);
            check("t5_busy", 64'(WRITE_busy), 64'd1);
        end
        MEM_wreq_valid = 1'b0;
        consume();

        // 6: asynchronous reset during RESP
        start(32'h8000_0020, 64'h77, 3'd0);
        @(negedge clk);
        check("t6_in_resp", 64'(bready), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_bready", 64'(bready), 64'd0);
        check("t6_busy", 64'(WRITE_busy), 64'd0);
        check("t6_awvalid", 64'(awvalid), 64'd0);
        check("t6_wvalid", 64'(wvalid), 64'd0);
        check("t6_wdone", 64'(MEM_wdone_valid), 64'd0);
        check("t6_wreq_ready", 64'(MEM_wreq_ready), 64'd0);
        check("t6_error", 64'(WRITE_error), 64'd0);
        check("t6_wdata", wdata, 64'd0);
        check("t6_wstrb", 64'(wstrb), 64'd0);
        check("t6_awaddr", 64'(awaddr), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        start(32'h8000_0024, 64'hDEAD_BEEF, 3'd2);
        check("t6n_awvalid", 64'(awvalid), 64'd1);
        check("t6n_awaddr", 64'(awaddr), 64'h8000_0024);
        check("t6n_wdata", wdata, 64'hDEAD_BEEF_0000_0000);
        check("t6n_wstrb", 64'(wstrb), 64'hF0);
        @(negedge clk);
        b_resp(2'b00, 4'h0);
        check("t6n_error", 64'(WRITE_error), 64'd0);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
